// File: rtl/biriscv_v_alu_seq.sv
// Sequencer wrapping a combinational vector ALU: issue -> exec -> writeback.
// Define BIRISCV_VALU_STATS_EN to build the completed-op counter on stat_ops_o.
module biriscv_v_alu_seq #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            issue_valid_i,
  output logic            issue_accept_o,
  input  logic [31:0]     issue_opcode_i,
  input  logic [31:0]     issue_pc_i,
  input  logic            issue_invalid_i,
  input  logic [4:0]      issue_vd_idx_i,
  input  logic [4:0]      issue_va_idx_i,
  input  logic [4:0]      issue_vb_idx_i,
  input  logic [31:0]     issue_ra_operand_i,
  input  logic [VLEN-1:0] issue_va_operand_i,
  input  logic [VLEN-1:0] issue_vb_operand_i,
  input  logic [VLEN-1:0] issue_vmask_operand_i,

  output logic            alu_valid_o,
  output logic [31:0]     alu_opcode_o,
  output logic [31:0]     alu_ra_operand_o,
  output logic [VLEN-1:0] alu_va_operand_o,
  output logic [VLEN-1:0] alu_vb_operand_o,
  output logic [VLEN-1:0] alu_vmask_operand_o,
  input  logic [VLEN-1:0] alu_result_i,

  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [VLEN-1:0] wb_value_o,
  output logic [4:0]      wb_vd_idx_o,
  output logic [31:0]     wb_pc_o,
  output logic            wb_fault_o,

  input  logic            flush_i,
  output logic            busy_o,
  output logic [31:0]     stat_ops_o
);

  if (VLEN % ELEN != 0) begin : g_bad_cfg
    $error("VLEN must be a multiple of ELEN");
  end

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_EXEC = 3'b010;
  localparam logic [2:0] S_WB   = 3'b100;

  logic [2:0]  state_q;
  logic        init_q;
  logic [31:0] pc_q;
  logic [4:0]  vd_q;
  logic        inv_q;
  logic        hazard;
  logic        accept;

  assign hazard = (issue_va_idx_i == wb_vd_idx_o) |
                  (issue_vb_idx_i == wb_vd_idx_o);

  // init_q keeps the issue port closed for the first cycle out of reset
  always_comb begin
    accept = 1'b0;
    unique case (1'b1)
      state_q[0]: accept = issue_valid_i;
      state_q[2]: accept = issue_valid_i & wb_ready_i & ~hazard;
      default:    accept = 1'b0;
    endcase
    accept = accept & ~flush_i & init_q & ~rst_i;
  end

  assign issue_accept_o = accept;
  assign alu_valid_o    = state_q[1] & ~inv_q;
  assign wb_valid_o     = state_q[2];
  assign busy_o         = ~state_q[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (flush_i) begin
        state_q <= S_IDLE;
      end else begin
        unique case (1'b1)
          state_q[0]: if (accept) state_q <= S_EXEC;
          state_q[1]: state_q <= S_WB;
          state_q[2]: begin
            if (wb_ready_i)
              state_q <= accept ? S_EXEC : S_IDLE;
          end
          default:    state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_opcode_o        <= '0;
      alu_ra_operand_o    <= '0;
      alu_va_operand_o    <= '0;
      alu_vb_operand_o    <= '0;
      alu_vmask_operand_o <= '0;
      pc_q                <= '0;
      vd_q                <= '0;
      inv_q               <= 1'b0;
    end else if (accept) begin
      alu_opcode_o        <= issue_opcode_i;
      alu_ra_operand_o    <= issue_ra_operand_i;
      alu_va_operand_o    <= issue_va_operand_i;
      alu_vb_operand_o    <= issue_vb_operand_i;
      alu_vmask_operand_o <= issue_vmask_operand_i;
      pc_q                <= issue_pc_i;
      vd_q                <= issue_vd_idx_i;
      inv_q               <= issue_invalid_i;
    end
  end

  // an illegal op never reaches the ALU and retires a zero result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_value_o  <= '0;
      wb_vd_idx_o <= '0;
      wb_pc_o     <= '0;
      wb_fault_o  <= 1'b0;
    end else if (state_q[1] & ~flush_i) begin
      wb_value_o  <= inv_q ? '0 : alu_result_i;
      wb_vd_idx_o <= vd_q;
      wb_pc_o     <= pc_q;
      wb_fault_o  <= inv_q;
    end
  end

`ifdef BIRISCV_VALU_STATS_EN
  logic [31:0] stat_q;
  logic        handshake;

  assign handshake = state_q[2] & wb_ready_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stat_q <= '0;
    else if (handshake)
      stat_q <= stat_q + 32'd1;
  end

  assign stat_ops_o = stat_q;
`else
  assign stat_ops_o = '0;
`endif

endmodule
